// File: rtl/hps_led_pio_fx_if.sv
// Avalon-MM slave bus bundle for the LED PIO: word address, active-low write strobe,
// 32-bit data in both directions.
interface hps_led_pio_fx_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/hps_led_pio_fx.sv
// LED output PIO with atomic set/clear, per-bit hardware blink and global PWM brightness.
// out_port is registered one cycle after DATA, BLINK_EN, blink phase and PWM state.
module hps_led_pio_fx #(
    parameter int unsigned       WIDTH       = 10,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '1,
    parameter int unsigned       PRESC_W     = 24,
    parameter int unsigned       PRESC_RESET = 4_999_999,
    parameter bit                PWM_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hps_led_pio_fx_if.slave      avs,
    output logic [WIDTH-1:0]     out_port
);

    localparam logic [PRESC_W-1:0] PRESC_INIT = PRESC_W'(PRESC_RESET);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_BLINK_EN = 3'd1,
        REG_PRESCALE = 3'd2,
        REG_BRIGHT   = 3'd3,
        REG_OUTSET   = 3'd4,
        REG_OUTCLEAR = 3'd5,
        REG_STATUS   = 3'd6,
        REG_NONE     = 3'd7
    } reg_addr_e;

    reg_addr_e          addr;
    logic               wr;
    logic [WIDTH-1:0]   wdata;

    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   blink_en;
    logic [PRESC_W-1:0] prescale;
    logic [7:0]         bright;
    logic [7:0]         bright_rd;

    logic [PRESC_W-1:0] presc_cnt;
    logic               blink_phase;
    logic [7:0]         pwm_cnt;
    logic               pwm_on;
    logic               unused_bits;

    assign addr        = reg_addr_e'(avs.address);
    assign wr          = avs.chipselect & ~avs.write_n;
    assign wdata       = avs.writedata[WIDTH-1:0];
    assign unused_bits = &{1'b0, avs.writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            prescale <= PRESC_INIT;
            bright   <= '1;
        end else if (wr) begin
            case (addr)
                REG_DATA:     data     <= wdata;
                REG_BLINK_EN: blink_en <= wdata;
                REG_PRESCALE: prescale <= avs.writedata[PRESC_W-1:0];
                REG_BRIGHT:   bright   <= avs.writedata[7:0];
                REG_OUTSET:   data     <= data | wdata;
                REG_OUTCLEAR: data     <= data & ~wdata;
                default:      ;
            endcase
        end
    end

    // A PRESCALE write restarts the count and overrides a terminal-count toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wr && addr == REG_PRESCALE) begin
            presc_cnt <= '0;
        end else if (presc_cnt == prescale) begin
            presc_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    generate
        if (PWM_EN) begin : g_pwm
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pwm_cnt <= '0;
                end else if (pwm_cnt == 8'd254) begin
                    pwm_cnt <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + 8'd1;
                end
            end
            assign pwm_on    = (pwm_cnt < bright);
            assign bright_rd = bright;
        end else begin : g_no_pwm
            assign pwm_cnt   = '0;
            assign pwm_on    = 1'b1;
            assign bright_rd = 8'hFF;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= data & (~blink_en | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (addr)
            REG_DATA, REG_OUTSET, REG_OUTCLEAR: avs.readdata[WIDTH-1:0]   = data;
            REG_BLINK_EN:                       avs.readdata[WIDTH-1:0]   = blink_en;
            REG_PRESCALE:                       avs.readdata[PRESC_W-1:0] = prescale;
            REG_BRIGHT:                         avs.readdata[7:0]         = bright_rd;
            REG_STATUS:                         avs.readdata[8:0]         = {blink_phase, pwm_cnt};
            default:                            avs.readdata              = '0;
        endcase
    end

endmodule

// File: tb/tb_hps_led_pio_fx.sv
// Bench for hps_led_pio_fx: a cycle reference model queues the expected out_port at
// each rising edge and the monitor pops and compares it on the following falling edge.
module tb_hps_led_pio_fx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] out_port;

    hps_led_pio_fx_if bus();

    hps_led_pio_fx #(
        .WIDTH       (10),
        .RESET_VALUE (10'h3FF),
        .PRESC_W     (24),
        .PRESC_RESET (4_999_999),
        .PWM_EN      (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the register file, prescaler and PWM counter
    logic [9:0]  m_data;
    logic [9:0]  m_blink;
    logic [23:0] m_presc;
    logic [7:0]  m_bright;
    logic [23:0] m_pc;
    logic        m_phase;
    logic [7:0]  m_pcnt;
    logic [9:0]  sb[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= 10'h3FF;
            m_blink  <= '0;
            m_presc  <= 24'd4_999_999;
            m_bright <= 8'hFF;
            m_pc     <= '0;
            m_phase  <= 1'b0;
            m_pcnt   <= '0;
            sb.delete();
        end else begin
            sb.push_back(m_data & (~m_blink | {10{m_phase}}) & {10{m_pcnt < m_bright}});
            m_pcnt <= (m_pcnt == 8'd254) ? 8'd0 : m_pcnt + 8'd1;
            if (bus.chipselect && !bus.write_n && bus.address == 3'd2) begin
                m_pc <= '0;
            end else if (m_pc == m_presc) begin
                m_pc    <= '0;
                m_phase <= ~m_phase;
            end else begin
                m_pc <= m_pc + 24'd1;
            end
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data   <= bus.writedata[9:0];
                    3'd1: m_blink  <= bus.writedata[9:0];
                    3'd2: m_presc  <= bus.writedata[23:0];
                    3'd3: m_bright <= bus.writedata[7:0];
                    3'd4: m_data   <= m_data | bus.writedata[9:0];
                    3'd5: m_data   <= m_data & ~bus.writedata[9:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (sb.size() != 0) check_eq("out_port", 32'(out_port), 32'(sb.pop_front()));
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check_eq(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic read_status(input string tag);
        @(negedge clk);
        bus.address    = 3'd6;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check_eq(tag, bus.readdata, {23'd0, m_phase, m_pcnt});
        bus.chipselect = 1'b0;
    endtask

    logic prev;
    logic p0;
    logic exp_phase;
    int   last;
    int   ntog;
    int   cnt_on;
    int   cnt_odd;
    bit   found;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t1_out", 32'(out_port), 32'h3FF);
        bus_read(3'd0, 32'h3FF, "t1_data");
        bus_read(3'd1, 32'h0, "t1_blink");
        bus_read(3'd2, 32'h4C4B3F, "t1_presc");
        bus_read(3'd3, 32'hFF, "t1_bright");
        bus_read(3'd7, 32'h0, "t1_addr7");
        read_status("t1_status");

        // Plain write, atomic set and clear
        bus_write(3'd0, 32'h0A5);
        bus_write(3'd4, 32'h300);
        bus_write(3'd5, 32'h005);
        @(posedge clk);
        #1;
        check_eq("t2_out", 32'(out_port), 32'h3A0);
        bus_read(3'd0, 32'h3A0, "t2_data");
        bus_read(3'd4, 32'h3A0, "t2_outset_rd");
        bus_read(3'd5, 32'h3A0, "t2_outclr_rd");
        bus_write(3'd4, 32'hFFFF_FC00);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd0, 32'h3A0, "t2_ignored");
        bus_read(3'd7, 32'h0, "t2_addr7");

        // Blink with half-period of 4 cycles
        bus_write(3'd2, 32'd3);
        bus_write(3'd1, 32'h001);
        bus_write(3'd0, 32'h001);
        @(negedge clk);
        prev = out_port[0];
        last = -1;
        ntog = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_port[0] !== prev) begin
                if (last >= 0) check_eq("t3_period", 32'(i - last), 32'd4);
                last = i;
                ntog++;
                prev = out_port[0];
            end
        end
        check_eq("t3_toggles", 32'(ntog), 32'd10);
        read_status("t3_status_a");
        repeat (3) @(posedge clk);
        read_status("t3_status_b");

        // PWM at brightness 64, then fully off
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd3, 32'd64);
        @(negedge clk);
        cnt_on  = 0;
        cnt_odd = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (out_port == 10'h3FF) cnt_on++;
            else if (out_port != 10'h000) cnt_odd++;
        end
        check_eq("t4_on64", 32'(cnt_on), 32'd64);
        check_eq("t4_odd", 32'(cnt_odd), 32'd0);
        bus_write(3'd3, 32'd0);
        bus_read(3'd3, 32'd0, "t4_bright0");
        cnt_on = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (out_port != 10'h000) cnt_on++;
        end
        check_eq("t4_off", 32'(cnt_on), 32'd0);
        bus_write(3'd3, 32'd255);

        // PRESCALE write coinciding with terminal count
        bus_write(3'd2, 32'd5);
        bus_write(3'd1, 32'h001);
        bus_write(3'd0, 32'h001);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_pc == 24'd4) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t5_found", 32'(found), 32'd1);
        if (found) begin
            p0 = m_phase;
            bus_write(3'd2, 32'd5);
            for (int k = 0; k <= 6; k++) begin
                @(negedge clk);
                bus.address    = 3'd6;
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b1;
                #1;
                exp_phase = (k < 6) ? p0 : ~p0;
                check_eq("t5_phase", 32'(bus.readdata[8]), 32'(exp_phase));
                bus.chipselect = 1'b0;
            end
        end

        // Asynchronous reset in the middle of blinking
        bus_write(3'd2, 32'd2);
        bus_write(3'd1, 32'h3FF);
        bus_write(3'd0, 32'h155);
        bus_write(3'd3, 32'd200);
        repeat (7) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t6_out_async", 32'(out_port), 32'h3FF);
        bus_read(3'd0, 32'h3FF, "t6_data");
        bus_read(3'd1, 32'h0, "t6_blink");
        bus_read(3'd2, 32'h4C4B3F, "t6_presc");
        bus_read(3'd3, 32'hFF, "t6_bright");
        bus_read(3'd6, 32'h0, "t6_status");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6_out_after", 32'(out_port), 32'h3FF);
        read_status("t6_status_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
